// File: rtl/dmem_pkg.sv
// Shared types and sizes for the data-memory port arbiter.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 5;
  localparam int DMEM_DATA_W = 32;

  // Owner of the read whose data comes back next cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  // NORMAL: CPU has priority; DMA_FORCE: DMA has priority for one cycle
  typedef enum logic {
    NORMAL    = 1'b0,
    DMA_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating 4-bit count of consecutive CPU wins while the DMA waits.
// o_at_max flags the increment that brings the count to MAX, so the
// arbiter can switch to forced-DMA on the very next cycle.
module dmem_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam logic [3:0] MAX_M1 = 4'(MAX - 1);

  logic [3:0] r_cnt;

  // Clear wins over increment; the count holds at 15 instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_inc && (r_cnt != 4'hF)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_at_max = i_inc && (r_cnt >= MAX_M1);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter between the CPU MEM stage and a DMA/loader.
// One access per cycle, read data routed back to its owner one cycle later.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_stall,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic              o_dma_gnt,
  output logic              o_dma_rvalid,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;
  owner_e      r_rd_owner;
  owner_e      w_rd_owner_nxt;
  logic        w_gnt_cpu;
  logic        w_gnt_dma;
  logic        w_starve_inc;
  logic        w_starve_clr;
  logic        w_at_max;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  // Grant select; forced-DMA only applies while the DMA is still asking,
  // and no grant is issued while reset is asserted
  always_comb begin
    w_gnt_cpu = 1'b0;
    w_gnt_dma = 1'b0;
    if (rst_n) begin
      if ((r_state == DMA_FORCE) && i_dma_req) begin
        w_gnt_dma = 1'b1;
      end else if (i_cpu_req) begin
        w_gnt_cpu = 1'b1;
      end else if (i_dma_req) begin
        w_gnt_dma = 1'b1;
      end
    end
  end

  // Only a CPU win over a waiting DMA in NORMAL extends the starvation run
  assign w_starve_inc = (r_state == NORMAL) && w_gnt_cpu && i_dma_req;
  assign w_starve_clr = !w_starve_inc;

  dmem_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_starve_inc),
    .i_clr    (w_starve_clr),
    .o_at_max (w_at_max)
  );

  // Next-state: forced-DMA lasts exactly one cycle whatever happens in it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      NORMAL:    if (w_at_max) w_state_nxt = DMA_FORCE;
      DMA_FORCE: w_state_nxt = NORMAL;
      default:   w_state_nxt = NORMAL;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= NORMAL;
    else        r_state <= w_state_nxt;
  end

  // Memory-side payload mux, all zero when idle
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_gnt_cpu) begin
      o_mem_we    = i_cpu_we;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
    end else if (w_gnt_dma) begin
      o_mem_we    = i_dma_we;
      o_mem_addr  = i_dma_addr;
      o_mem_wdata = i_dma_wdata;
    end
  end

  assign o_mem_en    = w_gnt_cpu || w_gnt_dma;
  assign o_cpu_stall = i_cpu_req && !w_gnt_cpu;
  assign o_dma_gnt   = w_gnt_dma;

  // Tag each granted read with its owner; writes and idle cycles tag NONE
  always_comb begin
    w_rd_owner_nxt = OWN_NONE;
    if (w_gnt_cpu && !i_cpu_we)      w_rd_owner_nxt = OWN_CPU;
    else if (w_gnt_dma && !i_dma_we) w_rd_owner_nxt = OWN_DMA;
  end

  // Read owner register; reset drops any pending return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_owner <= OWN_NONE;
    else        r_rd_owner <= w_rd_owner_nxt;
  end

  // Capture returned data so each owner's rdata holds until its next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      if (r_rd_owner == OWN_CPU) r_cpu_rdata <= i_mem_rdata;
      if (r_rd_owner == OWN_DMA) r_dma_rdata <= i_mem_rdata;
    end
  end

  // Memory data is passed straight through on the return cycle
  assign o_cpu_rvalid = (r_rd_owner == OWN_CPU);
  assign o_dma_rvalid = (r_rd_owner == OWN_DMA);
  assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : r_cpu_rdata;
  assign o_dma_rdata  = o_dma_rvalid ? i_mem_rdata : r_dma_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural synchronous memory.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [4:0]  dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] mem [0:31];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cpu_req    (cpu_req),
    .i_cpu_we     (cpu_we),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .o_cpu_stall  (cpu_stall),
    .o_cpu_rvalid (cpu_rvalid),
    .o_cpu_rdata  (cpu_rdata),
    .i_dma_req    (dma_req),
    .i_dma_we     (dma_we),
    .i_dma_addr   (dma_addr),
    .i_dma_wdata  (dma_wdata),
    .o_dma_gnt    (dma_gnt),
    .o_dma_rvalid (dma_rvalid),
    .o_dma_rdata  (dma_rdata),
    .o_mem_en     (mem_en),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  // Synchronous single-port memory model
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle();
    cpu_req = 1'b1;
    dma_req = 1'b1;
    #3;
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
    checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL rst_dma_gnt got=%b exp=0", dma_gnt); end
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rst_cpu_stall got=%b exp=1", cpu_stall); end
    checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b%b exp=00", cpu_rvalid, dma_rvalid); end
    checks++; if (cpu_rdata !== 32'd0 || dma_rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0/0", cpu_rdata, dma_rdata); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_load;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3;
    #3;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'd3) begin failures++; $display("FAIL load_issue got en=%b we=%b addr=%0d exp en=1 we=0 addr=3", mem_en, mem_we, mem_addr); end
    checks++; if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin failures++; $display("FAIL load_stall got stall=%b gnt=%b exp 0 0", cpu_stall, dma_gnt); end
    tick();
    cpu_req = 1'b0;
    #3;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL load_return got v=%b d=%h exp v=1 d=deadbeef", cpu_rvalid, cpu_rdata); end
    checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL load_dma_rvalid got=%b exp=0", dma_rvalid); end
    tick();
    #3;
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL load_hold got v=%b d=%h exp v=0 d=deadbeef", cpu_rvalid, cpu_rdata); end
  endtask

  task automatic test_simultaneous;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 5'd2; dma_wdata = 32'h55;
    #3;
    checks++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_addr !== 5'd1 || mem_we !== 1'b0) begin failures++; $display("FAIL simul_cpu_wins got gnt=%b stall=%b addr=%0d we=%b exp 0 0 1 0", dma_gnt, cpu_stall, mem_addr, mem_we); end
    tick();
    cpu_req = 1'b0;
    #3;
    checks++; if (dma_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 5'd2 || mem_wdata !== 32'h55) begin failures++; $display("FAIL simul_dma_write got gnt=%b we=%b addr=%0d wd=%h exp 1 1 2 55", dma_gnt, mem_we, mem_addr, mem_wdata); end
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'd1) begin failures++; $display("FAIL simul_cpu_return got v=%b d=%h exp v=1 d=1", cpu_rvalid, cpu_rdata); end
    tick();
    dma_req = 1'b0;
    #3;
    checks++; if (mem_en !== 1'b0 || cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin failures++; $display("FAIL simul_after got en=%b cv=%b dv=%b exp 0 0 0", mem_en, cpu_rvalid, dma_rvalid); end
  endtask

  task automatic test_starvation;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 5'd5;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      if (k == 5) dma_req = 1'b0;
      #3;
      checks++; if (dma_gnt !== (k == 4)) begin failures++; $display("FAIL starve_gnt k=%0d got=%b exp=%b", k, dma_gnt, (k == 4)); end
      checks++; if (cpu_stall !== (k == 4)) begin failures++; $display("FAIL starve_stall k=%0d got=%b exp=%b", k, cpu_stall, (k == 4)); end
      checks++; if (mem_addr !== ((k == 4) ? 5'd5 : 5'd0)) begin failures++; $display("FAIL starve_addr k=%0d got=%0d exp=%0d", k, mem_addr, ((k == 4) ? 5 : 0)); end
      if (k == 5) begin
        checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'd5) begin failures++; $display("FAIL starve_dma_return got v=%b d=%h exp v=1 d=5", dma_rvalid, dma_rdata); end
      end
    end
    tick();
    idle();
  endtask

  task automatic test_alternating;
    tick();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 5'd7;
    #3;
    checks++; if (dma_gnt !== 1'b1 || mem_addr !== 5'd7) begin failures++; $display("FAIL alt_dma_issue got gnt=%b addr=%0d exp 1 7", dma_gnt, mem_addr); end
    tick();
    dma_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd8;
    #3;
    checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'd7 || cpu_rvalid !== 1'b0) begin failures++; $display("FAIL alt_dma_return got dv=%b dd=%h cv=%b exp 1 7 0", dma_rvalid, dma_rdata, cpu_rvalid); end
    checks++; if (mem_addr !== 5'd8 || cpu_stall !== 1'b0) begin failures++; $display("FAIL alt_cpu_issue got addr=%0d stall=%b exp 8 0", mem_addr, cpu_stall); end
    tick();
    cpu_req = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 5'd2;
    #3;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'd8 || dma_rvalid !== 1'b0 || dma_rdata !== 32'd7) begin failures++; $display("FAIL alt_cpu_return got cv=%b cd=%h dv=%b dd=%h exp 1 8 0 7", cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata); end
    tick();
    idle();
    #3;
    checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h55 || cpu_rvalid !== 1'b0) begin failures++; $display("FAIL alt_written_word got dv=%b dd=%h cv=%b exp 1 55 0", dma_rvalid, dma_rdata, cpu_rvalid); end
  endtask

  task automatic test_reset_mid_read;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd4;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 5'd6;
    tick();
    tick();
    cpu_addr = 5'd3;
    #3;
    rst_n = 1'b0;
    tick();
    #2;
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'd0) begin failures++; $display("FAIL rstmid_dropped got v=%b d=%h exp v=0 d=0", cpu_rvalid, cpu_rdata); end
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rstmid_mem_en got=%b exp=0", mem_en); end
    rst_n = 1'b1;
    cpu_addr = 5'd0;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin tick(); #3; end
      checks++; if (dma_gnt !== (k == 4)) begin failures++; $display("FAIL rstmid_starve k=%0d got=%b exp=%b", k, dma_gnt, (k == 4)); end
    end
    tick();
    idle();
  endtask

  task automatic test_force_dropped;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd9;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 5'd10;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      if (k == 4) dma_req = 1'b0;
      if (k == 5) dma_req = 1'b1;
      #3;
      checks++; if (dma_gnt !== (k == 9) || cpu_stall !== (k == 9)) begin failures++; $display("FAIL drop_gnt k=%0d got gnt=%b stall=%b exp %b", k, dma_gnt, cpu_stall, (k == 9)); end
      if (k == 4) begin
        checks++; if (mem_en !== 1'b1 || mem_addr !== 5'd9) begin failures++; $display("FAIL drop_cpu_granted got en=%b addr=%0d exp 1 9", mem_en, mem_addr); end
      end
    end
    tick();
    idle();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    mem[3] = 32'hDEADBEEF;
    test_reset();
    test_cpu_load();
    test_simultaneous();
    test_starvation();
    test_alternating();
    test_reset_mid_read();
    test_force_dropped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
